// File: rtl/dbus_arbiter.sv
// ============================================================================
// Module   : dbus_arbiter
// Purpose  : Core/DMA arbiter for the single-port data bus, with RAM/IO decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dbus_arbiter #(
  parameter int          DATA_W   = 32,
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] IO_BASE  = 32'h0000_0080,
  parameter int          MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              io_we,
  output logic              io_re,
  output logic [ADDR_W-1:0] io_addr,
  output logic [DATA_W-1:0] io_wdata,
  input  logic [DATA_W-1:0] io_rdata
);

  localparam logic [0:0]        S_CPU     = 1'b0;
  localparam logic [0:0]        S_FORCE   = 1'b1;
  localparam logic [ADDR_W-1:0] IO_BASE_A = ADDR_W'(IO_BASE);
  localparam logic [3:0]        MAX_W4    = 4'(MAX_WAIT);
  localparam logic [4:0]        MAX_W5    = 5'(MAX_WAIT);

  logic [0:0]        state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              dma_rvalid_q, dma_rvalid_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

  logic              cpu_sel, dma_sel, own_we, own_re, is_io;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata, own_rdata;
  logic [4:0]        wait_inc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_CPU;
      wait_cnt_q   <= 4'd0;
      dma_rvalid_q <= 1'b0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      dma_rvalid_q <= dma_rvalid_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  // Next state, wait counter and DMA read capture.
  always_comb begin
    state_d  = state_q;
    wait_inc = {1'b0, wait_cnt_q} + 5'd1;
    if (dma_gnt || !dma_req)
      wait_cnt_d = 4'd0;
    else if (wait_cnt_q >= MAX_W4)
      wait_cnt_d = wait_cnt_q;
    else
      wait_cnt_d = wait_cnt_q + 4'd1;
    case (state_q)
      S_CPU:   if (dma_req && !dma_gnt && (wait_inc >= MAX_W5)) state_d = S_FORCE;
      S_FORCE: state_d = S_CPU;
      default: state_d = S_CPU;
    endcase
    dma_rvalid_d = dma_gnt & ~dma_we;
    dma_rdata_d  = dma_rvalid_d ? own_rdata : dma_rdata_q;
  end

  // Owner selection and decode; nothing is granted while reset is high.
  always_comb begin
    cpu_sel = 1'b0;
    dma_sel = 1'b0;
    if (!reset) begin
      if (state_q == S_FORCE)     dma_sel = dma_req;
      else if (cpu_re || cpu_we)  cpu_sel = 1'b1;
      else                        dma_sel = dma_req;
    end
    own_addr  = dma_sel ? dma_addr  : cpu_addr;
    own_wdata = dma_sel ? dma_wdata : cpu_wdata;
    own_we    = (dma_sel & dma_we)  | (cpu_sel & cpu_we);
    own_re    = (dma_sel & ~dma_we) | (cpu_sel & cpu_re);
    is_io     = (own_addr >= IO_BASE_A);
    own_rdata = is_io ? io_rdata : ram_rdata;

    dma_gnt    = dma_sel;
    ram_we     = own_we & ~is_io;
    io_we      = own_we & is_io;
    io_re      = own_re & is_io;
    ram_addr   = own_addr;
    ram_wdata  = own_wdata;
    io_addr    = own_addr;
    io_wdata   = own_wdata;
    cpu_rdata  = (cpu_addr >= IO_BASE_A) ? io_rdata : ram_rdata;
    cpu_stall  = (state_q == S_FORCE);
    dma_rvalid = dma_rvalid_q;
    dma_rdata  = dma_rdata_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_dbus_arbiter.sv
// ============================================================================
// Module   : tb_dbus_arbiter
// Purpose  : Scoreboard bench for dbus_arbiter (bus writes and DMA read data).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dbus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_re, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, ram_rdata, io_rdata;
  logic [31:0] cpu_rdata, dma_rdata, ram_addr, ram_wdata, io_addr, io_wdata;
  logic        cpu_stall, dma_gnt, dma_rvalid, ram_we, io_we, io_re;

  typedef struct packed {
    logic        io;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];
  wr_t         mon_e;
  logic [31:0] mon_d;
  int          n_checks = 0;
  int          n_fail   = 0;

  dbus_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .io_we(io_we), .io_re(io_re), .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic io, input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.io = io; e.addr = a; e.data = d;
    exp_wr.push_back(e);
  endtask

  // Monitor: every bus write and every DMA read response is matched in order.
  always @(negedge clk) begin
    if (ram_we || io_we) begin
      if (exp_wr.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL bus_write: unexpected write ram_we=%0b io_we=%0b addr=%h (t=%0t)",
                 ram_we, io_we, io_we ? io_addr : ram_addr, $time);
      end else begin
        mon_e = exp_wr.pop_front();
        chk("wr_region_io", {31'd0, io_we}, {31'd0, mon_e.io});
        chk("wr_region_ram", {31'd0, ram_we}, {31'd0, ~mon_e.io});
        chk("wr_addr", io_we ? io_addr : ram_addr, mon_e.addr);
        chk("wr_data", io_we ? io_wdata : ram_wdata, mon_e.data);
      end
    end
    if (dma_rvalid) begin
      if (exp_rd.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dma_read: unexpected rvalid data=%h (t=%0t)", dma_rdata, $time);
      end else begin
        mon_d = exp_rd.pop_front();
        chk("dma_rdata", dma_rdata, mon_d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int i, j, k, forced, idx;
    reset = 1'b1;
    cpu_re = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    ram_rdata = 0; io_rdata = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_cpu_stall", {31'd0, cpu_stall}, 0);
    chk("rst_dma_rvalid", {31'd0, dma_rvalid}, 0);
    chk("rst_dma_rdata", dma_rdata, 0);
    chk("rst_dma_gnt", {31'd0, dma_gnt}, 0);
    chk("rst_strobes", {29'd0, ram_we, io_we, io_re}, 0);
    chk("rst_wait_cnt", {28'd0, dut.wait_cnt_q}, 0);

    // Core stores: RAM, IO at exactly IO_BASE, RAM at IO_BASE-4.
    tick(); cpu_we = 1; cpu_addr = 32'h64; cpu_wdata = 7; push_wr(0, 32'h64, 7);
    @(negedge clk); chk("st64_io_we", {31'd0, io_we}, 0);
    tick(); cpu_addr = 32'h80; cpu_wdata = 32'h5A; push_wr(1, 32'h80, 32'h5A);
    @(negedge clk); chk("st80_ram_we", {31'd0, ram_we}, 0);
    tick(); cpu_addr = 32'h7C; cpu_wdata = 32'h11; push_wr(0, 32'h7C, 32'h11);
    @(negedge clk);

    // Idle-slot DMA: RAM read, IO read, RAM write.
    tick(); cpu_we = 0; dma_req = 1; dma_we = 0; dma_addr = 32'h10; ram_rdata = 32'h1234;
    exp_rd.push_back(32'h1234);
    @(negedge clk); chk("idle_gnt_rd", {31'd0, dma_gnt}, 1); chk("idle_stall", {31'd0, cpu_stall}, 0);
    tick(); dma_addr = 32'h84; io_rdata = 32'hBEEF; exp_rd.push_back(32'hBEEF);
    @(negedge clk); chk("idle_io_re", {31'd0, io_re}, 1);
    tick(); dma_we = 1; dma_addr = 32'h20; dma_wdata = 32'hCAFE; push_wr(0, 32'h20, 32'hCAFE);
    @(negedge clk); chk("idle_gnt_wr", {31'd0, dma_gnt}, 1);
    tick(); dma_req = 0; dma_we = 0;
    @(negedge clk); chk("rvalid_pulse", {31'd0, dma_rvalid}, 0); chk("rdata_hold", dma_rdata, 32'hBEEF);

    // Continuous contention: forced slot every 5th cycle.
    i = 0; k = 0; forced = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      cpu_we = 1; cpu_addr = i * 4; cpu_wdata = 32'h100 + i;
      dma_req = 1; dma_we = 1; dma_addr = 32'h90; dma_wdata = 32'hD0 + k;
      if (c % 5 == 0) push_wr(1, 32'h90, 32'hD0 + k);
      else begin
        idx = (c - 1) - (c - 1) / 5;
        push_wr(0, idx * 4, 32'h100 + idx);
      end
      @(negedge clk);
      chk("cont_stall", {31'd0, cpu_stall}, (c % 5 == 0) ? 1 : 0);
      chk("cont_gnt", {31'd0, dma_gnt}, (c % 5 == 0) ? 1 : 0);
      if (dma_gnt) begin forced++; k++; end
      if (!cpu_stall) i++;
    end
    tick(); cpu_we = 0; dma_req = 0;
    @(negedge clk);
    chk("cont_forced", forced, 4);
    chk("cont_core_done", i, 16);

    // DMA request withdrawn during the forced slot.
    j = 0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      cpu_we = 1; cpu_addr = 32'h40 + j * 4; cpu_wdata = 32'h200 + j;
      dma_req = (c != 5); dma_we = 1; dma_addr = 32'h94; dma_wdata = 32'hEE;
      if (c == 6) dma_req = 0;
      if (c != 5) begin
        idx = (c < 5) ? c - 1 : 4;
        push_wr(0, 32'h40 + idx * 4, 32'h200 + idx);
      end
      @(negedge clk);
      if (c == 5) begin
        chk("drop_stall", {31'd0, cpu_stall}, 1);
        chk("drop_gnt", {31'd0, dma_gnt}, 0);
      end
      if (!cpu_stall) j++;
    end
    chk("drop_core_done", j, 5);

    // Reset asserted in the middle of a forced slot.
    for (int c = 1; c <= 4; c++) begin
      tick();
      cpu_we = 1; cpu_addr = 32'h60; cpu_wdata = 32'h300;
      dma_req = 1; dma_we = 1; dma_addr = 32'h98; dma_wdata = 32'h77;
      push_wr(0, 32'h60, 32'h300);
      @(negedge clk);
    end
    tick();
    chk("force_stall", {31'd0, cpu_stall}, 1);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_stall", {31'd0, cpu_stall}, 0);
    chk("rst_mid_strobes", {28'd0, ram_we, io_we, io_re, dma_gnt}, 0);
    tick();
    chk("rst_hold_strobes", {28'd0, ram_we, io_we, io_re, dma_gnt}, 0);
    reset = 1'b0; cpu_we = 0; dma_req = 0; dma_we = 0;
    @(negedge clk);
    chk("rst_rel_state", {31'd0, dut.state_q}, 0);
    chk("rst_rel_stall", {31'd0, cpu_stall}, 0);
    chk("rst_rel_rdata", dma_rdata, 0);

    tick(); tick();
    @(negedge clk);
    chk("wr_queue_empty", exp_wr.size(), 0);
    chk("rd_queue_empty", exp_rd.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Shares the single-port data bus between two masters: the single-cycle core's data port and a DMA/IO-master port.
- The data bus consists of data RAM plus a memory-mapped IO window.
- The core has fixed priority. The DMA master gets idle cycles; once its wait count saturates it is guaranteed one cycle, during which the core is stalled.
- Also decodes addresses: RAM region below IO_BASE, IO region at or above IO_BASE.

Parameters:
- DATA_W, 32, data width of all buses.
- ADDR_W, 32, byte-address width.
- IO_BASE, 32'h0000_0080, first byte address of the IO region. Addresses >= IO_BASE go to IO.
- MAX_WAIT, 4, number of waited cycles after which DMA is forced a slot. Range 1..15.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- cpu_re  input  1  core load in progress this cycle.
- cpu_we  input  1  core store in progress this cycle.
- cpu_addr  input  ADDR_W  core byte address.
- cpu_wdata  input  DATA_W  core store data.
- cpu_rdata  output  DATA_W  combinational read data to the core.
- cpu_stall  output  1  registered; core must hold PC and suppress register/memory writes.
- dma_req  input  1  DMA request; held high until dma_gnt.
- dma_we  input  1  DMA write (1) / read (0).
- dma_addr  input  ADDR_W  DMA byte address.
- dma_wdata  input  DATA_W  DMA write data.
- dma_gnt  output  1  combinational; DMA access performed this cycle.
- dma_rdata  output  DATA_W  registered DMA read data.
- dma_rvalid  output  1  registered; one-cycle pulse qualifying dma_rdata.
- ram_we  output  1  RAM write enable.
- ram_addr  output  ADDR_W  RAM address.
- ram_wdata  output  DATA_W  RAM write data.
- ram_rdata  input  DATA_W  combinational RAM read data.
- io_we  output  1  IO write strobe.
- io_re  output  1  IO read strobe (for read-side-effect registers).
- io_addr  output  ADDR_W  IO address.
- io_wdata  output  DATA_W  IO write data.
- io_rdata  input  DATA_W  combinational IO read data.

Behaviour:

State and reset:
- State register: S_CPU or S_FORCE.
- Wait counter: wait_cnt, 4 bits, saturates at MAX_WAIT.
- Reset: state=S_CPU, wait_cnt=0, cpu_stall=0, dma_rvalid=0, dma_rdata=0. All combinational outputs then follow from state with no grant.

Owner selection (combinational):
- In S_CPU with cpu_re|cpu_we: owner=CPU, dma_gnt=0.
- In S_CPU, core idle, dma_req=1: owner=DMA, dma_gnt=1 (idle-slot grant, zero latency).
- In S_FORCE: owner=DMA, dma_gnt=dma_req. Core inputs are ignored.
- No owner: all strobes 0. ram_addr, ram_wdata, io_addr and io_wdata carry the core's values.

Decode:
- is_io = owner_addr >= IO_BASE (unsigned compare).
- ram_we = owner_we & ~is_io.
- io_we = owner_we & is_io.
- io_re = owner_re & is_io.
- cpu_rdata = cpu_addr>=IO_BASE ? io_rdata : ram_rdata. It is driven every cycle regardless of owner; it is valid only when the core is not stalled.

Wait counter (updated each clock edge):
- Clears when dma_gnt=1 or dma_req=0.
- Otherwise increments, saturating.

Transitions:
- S_CPU -> S_FORCE when dma_req & ~dma_gnt & (wait_cnt+1 >= MAX_WAIT).
- S_FORCE -> S_CPU unconditionally after one cycle.
- cpu_stall = (state==S_FORCE), so it is registered and high for exactly one cycle per forced grant.
- The core repeats its stalled instruction the next cycle. Its blocked access is never performed during the stall.

DMA read response:
- On an edge where dma_gnt & ~dma_we: dma_rdata <= selected read data, dma_rvalid <= 1.
- Otherwise dma_rvalid <= 0 and dma_rdata holds.
- Read latency: 1 cycle after the grant.
- DMA writes complete at the grant edge with no response.

Boundary conditions:
- Simultaneous core access and forced slot: the forced slot wins.
- dma_req dropped while in S_FORCE: no access, the stall cycle is still spent, return to S_CPU.
- Back-to-back DMA requests with the core continuously busy: one forced slot every MAX_WAIT+1 cycles.
- Address exactly IO_BASE: IO region. IO_BASE-4: RAM.
- Reset asserted mid-S_FORCE: cpu_stall and dma_rvalid drop asynchronously. No strobe is asserted while reset is high.

Test Plan:
- Reset then idle: all strobes 0, cpu_stall=0, dma_rvalid=0, wait_cnt=0.
- Core store cpu_we=1 addr=0x64 data=7, no DMA -> ram_we=1, ram_addr=0x64, io_we=0. Store to 0x80 data=0x5A -> io_we=1, io_wdata=0x5A, ram_we=0.
- Core idle, DMA read 0x10 with ram_rdata=0x1234 -> dma_gnt=1 same cycle; next cycle dma_rvalid=1, dma_rdata=0x1234; pulse lasts one cycle.
- Core accessing every cycle, dma_req held, MAX_WAIT=4 -> dma_gnt=0 for 4 cycles, then cpu_stall=1 and dma_gnt=1 in the 5th cycle; the DMA write lands at its address; cpu_stall=0 the following cycle.
- Continuous contention for 20 cycles -> exactly 4 forced grants, no core store lost, each stalled store performed once in the cycle after its stall.
- Reset pulsed during S_FORCE -> cpu_stall falls immediately, no ram_we or io_we while reset is high, state S_CPU after release.
